// File: rtl/rps_match_scorer.sv
// Rock-paper-scissors match scorer: tallies round results and flags the match winner.
// Ports: clk, rst_n, ena, result_valid, result[1:0], clear in; p1/p2_score, round_count,
// round_done, match_over, match_winner[1:0], invalid_count out.
// Optional feature: define RPS_SCORER_INVALID_CNT_EN to build the invalid-result counter.
module rps_match_scorer #(
  parameter int WIN_TARGET = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       result_valid,
  input  logic [1:0] result,
  input  logic       clear,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic [3:0] round_count,
  output logic       round_done,
  output logic       match_over,
  output logic [1:0] match_winner,
  output logic [3:0] invalid_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } state_t;

  localparam logic [3:0] WIN = 4'(WIN_TARGET);

  state_t state_q, state_d;

  logic       accept;
  logic       p1_pt, p2_pt;
  logic       p1_win, p2_win;
  logic [3:0] p1_inc, p2_inc;
  logic [3:0] rc_inc;

  logic [3:0] p1_d, p2_d, rc_d;
  logic       done_d, over_d;
  logic [1:0] winner_d;

  assign accept = ena & result_valid & ~clear
                & (state_q != OVER);
  assign p1_pt  = (result == 2'b01);
  assign p2_pt  = (result == 2'b10);
  assign p1_inc = p1_score + 4'd1;
  assign p2_inc = p2_score + 4'd1;
  assign p1_win = p1_pt & (p1_inc == WIN);
  assign p2_win = p2_pt & (p2_inc == WIN);
  assign rc_inc = (round_count == 4'hF) ?
                  round_count : round_count + 4'd1;

  // state register (outputs are registered alongside it)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      p1_score     <= '0;
      p2_score     <= '0;
      round_count  <= '0;
      round_done   <= 1'b0;
      match_over   <= 1'b0;
      match_winner <= '0;
    end else begin
      state_q      <= state_d;
      p1_score     <= p1_d;
      p2_score     <= p2_d;
      round_count  <= rc_d;
      round_done   <= done_d;
      match_over   <= over_d;
      match_winner <= winner_d;
    end
  end

  // next state
  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      !ena:                        state_d = state_q;
      ena & clear:                 state_d = IDLE;
      accept & (p1_win | p2_win):  state_d = OVER;
      accept & ~(p1_win | p2_win): state_d = PLAY;
      default:                     state_d = state_q;
    endcase
  end

  // next registered outputs
  always_comb begin
    p1_d     = p1_score;
    p2_d     = p2_score;
    rc_d     = round_count;
    done_d   = 1'b0;
    winner_d = match_winner;
    unique case (1'b1)
      ena & clear: begin
        p1_d     = '0;
        p2_d     = '0;
        rc_d     = '0;
        winner_d = '0;
      end
      accept: begin
        rc_d   = rc_inc;
        done_d = 1'b1;
        if (p1_pt) p1_d = p1_inc;
        if (p2_pt) p2_d = p2_inc;
        if (p1_win) winner_d = 2'b01;
        if (p2_win) winner_d = 2'b10;
      end
      default: ;
    endcase
    over_d = (state_d == OVER);
  end

`ifdef RPS_SCORER_INVALID_CNT_EN
  logic [3:0] inv_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inv_q <= '0;
    end else if (ena & clear) begin
      inv_q <= '0;
    end else if (accept & (result == 2'b11)
                 & (inv_q != 4'hF)) begin
      inv_q <= inv_q + 4'd1;
    end
  end

  assign invalid_count = inv_q;
`else
  assign invalid_count = '0;
`endif

endmodule

// File: tb/tb_rps_match_scorer.sv
// Self-checking bench for rps_match_scorer.
// Directed vectors checked against a behavioural match model every cycle.
module tb_rps_match_scorer;

  localparam int W = 3;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic       result_valid;
  logic [1:0] result;
  logic       clear;
  logic [3:0] p1_score;
  logic [3:0] p2_score;
  logic [3:0] round_count;
  logic       round_done;
  logic       match_over;
  logic [1:0] match_winner;
  logic [3:0] invalid_count;

  int tests;
  int failed;

  int m_p1, m_p2, m_rc, m_inv, m_winner;
  bit m_done, m_over;

  rps_match_scorer #(.WIN_TARGET(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .result_valid (result_valid),
    .result       (result),
    .clear        (clear),
    .p1_score     (p1_score),
    .p2_score     (p2_score),
    .round_count  (round_count),
    .round_done   (round_done),
    .match_over   (match_over),
    .match_winner (match_winner),
    .invalid_count(invalid_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic model_reset();
    m_p1 = 0; m_p2 = 0; m_rc = 0; m_inv = 0;
    m_winner = 0; m_done = 0; m_over = 0;
  endtask

  // One clock edge of the match as the rules describe it.
  task automatic model_step(input bit v, input int r,
                            input bit c, input bit e);
    if (!e) begin
      m_done = 0;
    end else if (c) begin
      model_reset();
    end else if (v && !m_over) begin
      m_done = 1;
      m_rc = (m_rc < 15) ? m_rc + 1 : 15;
      if (r == 1) m_p1++;
      if (r == 2) m_p2++;
`ifdef RPS_SCORER_INVALID_CNT_EN
      if (r == 3 && m_inv < 15) m_inv++;
`endif
      if (m_p1 == W) begin
        m_over = 1; m_winner = 1;
      end else if (m_p2 == W) begin
        m_over = 1; m_winner = 2;
      end
    end else begin
      m_done = 0;
    end
  endtask

  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic compare_all();
    check("p1_score", int'(p1_score), m_p1);
    check("p2_score", int'(p2_score), m_p2);
    check("round_count", int'(round_count), m_rc);
    check("round_done", int'(round_done), int'(m_done));
    check("match_over", int'(match_over), int'(m_over));
    check("match_winner", int'(match_winner), m_winner);
    check("invalid_count", int'(invalid_count), m_inv);
  endtask

  // Inputs change on the falling edge, are sampled on the rising
  // edge, and outputs are compared on the next falling edge.
  task automatic tick(input bit v, input logic [1:0] r,
                      input bit c, input bit e);
    result_valid = v;
    result       = r;
    clear        = c;
    ena          = e;
    @(posedge clk);
    model_step(v, int'(r), c, e);
    @(negedge clk);
    compare_all();
    result_valid = 1'b0;
    clear        = 1'b0;
  endtask

  logic [1:0] seq2 [5];

  initial begin
    tests = 0;
    failed = 0;
    model_reset();
    rst_n = 1'b0;
    ena = 1'b0;
    result_valid = 1'b0;
    result = 2'b00;
    clear = 1'b0;
    repeat (2) @(negedge clk);
    compare_all();
    check("reset_p1", int'(p1_score), 0);
    check("reset_over", int'(match_over), 0);
    rst_n = 1'b1;

    // P1 takes three straight rounds
    tick(1, 2'b01, 0, 1);
    check("lit_p1_1", int'(p1_score), 1);
    tick(1, 2'b01, 0, 1);
    check("lit_p1_2", int'(p1_score), 2);
    tick(1, 2'b01, 0, 1);
    check("lit_p1_3", int'(p1_score), 3);
    check("lit_over", int'(match_over), 1);
    check("lit_winner_p1", int'(match_winner), 1);
    check("lit_rc_3", int'(round_count), 3);
    tick(0, 2'b00, 0, 1);
    check("lit_done_low", int'(round_done), 0);

    // strobe while OVER is ignored, then clear
    tick(1, 2'b01, 0, 1);
    check("lit_over_p1_hold", int'(p1_score), 3);
    check("lit_over_rc_hold", int'(round_count), 3);
    check("lit_over_no_done", int'(round_done), 0);
    tick(0, 2'b00, 1, 1);
    check("lit_clr_p1", int'(p1_score), 0);
    check("lit_clr_over", int'(match_over), 0);
    check("lit_clr_winner", int'(match_winner), 0);

    // P2 wins with a tie and an invalid round in between
    seq2[0] = 2'b10; seq2[1] = 2'b00; seq2[2] = 2'b10;
    seq2[3] = 2'b11; seq2[4] = 2'b10;
    foreach (seq2[i]) tick(1, seq2[i], 0, 1);
    check("lit_p2_3", int'(p2_score), 3);
    check("lit_rc_5", int'(round_count), 5);
    check("lit_winner_p2", int'(match_winner), 2);
`ifdef RPS_SCORER_INVALID_CNT_EN
    check("lit_inv", int'(invalid_count), 1);
`else
    check("lit_inv", int'(invalid_count), 0);
`endif
    tick(0, 2'b00, 1, 1);

    // clear beats a simultaneous result
    tick(1, 2'b01, 1, 1);
    check("lit_clrpri_p1", int'(p1_score), 0);
    check("lit_clrpri_done", int'(round_done), 0);

    // enable low freezes everything
    tick(1, 2'b01, 0, 1);
    tick(1, 2'b01, 0, 0);
    check("lit_ena_p1", int'(p1_score), 1);
    check("lit_ena_done", int'(round_done), 0);
    tick(1, 2'b10, 1, 0);
    check("lit_ena_clr", int'(round_count), 1);

    // async reset mid-match at 2:1
    tick(1, 2'b01, 0, 1);
    tick(1, 2'b10, 0, 1);
    check("lit_p1_2b", int'(p1_score), 2);
    check("lit_p2_1b", int'(p2_score), 1);
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    check("lit_rst_p1", int'(p1_score), 0);
    check("lit_rst_rc", int'(round_count), 0);
    #1;
    rst_n = 1'b1;
    tick(1, 2'b10, 0, 1);
    check("lit_post_rst_rc", int'(round_count), 1);
    tick(0, 2'b00, 1, 1);

    // round counter saturation on ties
    for (int i = 0; i < 16; i++) tick(1, 2'b00, 0, 1);
    check("lit_rc_sat", int'(round_count), 15);
    check("lit_sat_p1", int'(p1_score), 0);
    check("lit_sat_over", int'(match_over), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/rps_match_scorer.md
RPS_MATCH_SCORER -- requirements
Module: rps_match_scorer

Interface
REQ-001 SHALL have parameter WIN_TARGET, default 3, round wins needed to take the match (legal 1..15).
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port ena  input  1  enable; low freezes all state.
REQ-005 SHALL have port result_valid  input  1  one-cycle strobe, upstream round result ready.
REQ-006 SHALL have port result  input  2  round outcome: 00 tie, 01 P1, 10 P2, 11 invalid.
REQ-007 SHALL have port clear  input  1  synchronous match restart.
REQ-008 SHALL have port p1_score  output  4  P1 round wins.
REQ-009 SHALL have port p2_score  output  4  P2 round wins.
REQ-010 SHALL have port round_count  output  4  accepted rounds, including ties and invalid.
REQ-011 SHALL have port round_done  output  1  one-cycle pulse, cycle after an accepted result.
REQ-012 SHALL have port match_over  output  1  high while in OVER state.
REQ-013 SHALL have port match_winner  output  2  00 none, 01 P1, 10 P2; valid when match_over.
REQ-014 SHALL have port invalid_count  output  4  invalid results in current match (see Configuration).

Function
REQ-015 SHALL implement states IDLE (no round accepted), PLAY, OVER; all outputs registered.
REQ-016 SHALL accept a result only on a rising edge with ena=1, result_valid=1, clear=0, state != OVER.
REQ-017 SHALL, on acceptance, update scores, round_count and state so they are visible the following cycle (latency 1), with round_done high for exactly that cycle.
REQ-018 SHALL increment p1_score on 01, p2_score on 10, neither on 00 or 11.
REQ-019 SHALL increment round_count on every accepted result, saturating at 15.
REQ-020 SHALL move IDLE->PLAY on first accepted result, unless that result completes the match.
REQ-021 SHALL move to OVER and set match_winner in the same edge that brings either score to WIN_TARGET.
REQ-022 SHALL ignore result_valid in OVER: no score, count or round_done change.
REQ-023 SHALL, on clear with ena=1 in any state, zero scores, counts, match_winner, round_done and return to IDLE next cycle.
REQ-024 SHALL give clear priority over a simultaneous result_valid; the result is dropped.
REQ-025 SHALL hold all state, with round_done low, on any edge where ena=0, regardless of other inputs.
REQ-026 SHALL ignore result_valid held high across cycles beyond per-edge acceptance, i.e. each qualifying edge is a separate round.

Reset
REQ-027 SHALL, while rst_n=0, asynchronously force state IDLE and all outputs to 0.
REQ-028 SHALL discard any result in flight when reset asserts mid-match; first post-reset acceptance is round 1.

Configuration
REQ-029 SHALL, with macro RPS_SCORER_INVALID_CNT_EN defined, increment invalid_count (saturating at 15) on each accepted 11 result, cleared by clear and reset.
REQ-030 SHALL, without RPS_SCORER_INVALID_CNT_EN, drive invalid_count constant 0 and instantiate no counter; all other behaviour unchanged.

Verification
REQ-031 SHALL cover: reset, strobes 01,01,01 (WIN_TARGET=3) -> p1_score 1,2,3; match_over=1, match_winner=01 one cycle after third strobe; round_count=3.
REQ-032 SHALL cover: strobes 10,00,10,11,10 -> p2_score=3, round_count=5, match_winner=10; with macro invalid_count=1, without 0.
REQ-033 SHALL cover: in OVER, strobe 01 -> p1_score, round_count unchanged, round_done stays 0; then clear -> all outputs 0 next cycle, state IDLE.
REQ-034 SHALL cover: clear and result_valid=1,result=01 same edge -> p1_score=0, round_done=0.
REQ-035 SHALL cover: ena=0 with strobe 01 -> no change; rst_n pulsed low mid-match after scores 2:1 -> outputs 0 immediately, without waiting for clk.
REQ-036 SHALL cover: 16 consecutive 00 strobes -> round_count saturates at 15, scores 0, match_over 0.
